// File: rtl/quad_decoder.sv
// rtl/quad_decoder.sv - quadrature encoder front end: sync, optional QDEC_FILTER_EN stability filter, step/dir/zero/err decode
module quad_decoder #(
  parameter int SYNC_STAGES = 2,
  parameter int FILTER_LEN  = 4,
  parameter int ERR_W       = 8
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             qa,
  input  logic             qb,
  input  logic             qi,
  output logic             step,
  output logic             dir,
  output logic             zero,
  output logic             err,
  output logic [ERR_W-1:0] err_cnt
);

  logic [SYNC_STAGES-1:0] sync_a, sync_b, sync_i;
  logic [2:0]             raw;    // {a, b, index} after synchronisation
  logic [2:0]             lines;  // {a, b, index} as seen by the decoder

  // Synchroniser chains for the three asynchronous pins
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync_a <= '0;
      sync_b <= '0;
      sync_i <= '0;
    end else begin
      sync_a <= {sync_a[SYNC_STAGES-2:0], qa};
      sync_b <= {sync_b[SYNC_STAGES-2:0], qb};
      sync_i <= {sync_i[SYNC_STAGES-2:0], qi};
    end
  end

  assign raw = {sync_a[SYNC_STAGES-1], sync_b[SYNC_STAGES-1], sync_i[SYNC_STAGES-1]};

`ifdef QDEC_FILTER_EN
  localparam int FCW = $clog2(FILTER_LEN + 1);
  // The filtered lines start at 0, so INIT must also wait out the filter
  localparam int INIT_WAIT = SYNC_STAGES + FILTER_LEN;

  logic [2:0]     filt;
  logic [FCW-1:0] fcnt [3];

  // Per-line stability filter: follow raw only after FILTER_LEN differing cycles
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      filt <= '0;
      for (int n = 0; n < 3; n++) fcnt[n] <= '0;
    end else begin
      for (int n = 0; n < 3; n++) begin
        if (raw[n] != filt[n]) begin
          if (fcnt[n] == FCW'(FILTER_LEN - 1)) begin
            filt[n] <= raw[n];
            fcnt[n] <= '0;
          end else begin
            fcnt[n] <= fcnt[n] + FCW'(1);
          end
        end else begin
          fcnt[n] <= '0;
        end
      end
    end
  end

  assign lines = filt;
`else
  // FILTER_LEN has no effect without the filter
  localparam int INIT_WAIT = SYNC_STAGES + 0 * FILTER_LEN;

  assign lines = raw;
`endif

  localparam int ICW = $clog2(INIT_WAIT + 1);

  typedef enum logic {S_INIT, S_TRACK} state_t;

  state_t         state, state_nxt;
  logic [ICW-1:0] init_cnt;
  logic [1:0]     prev, cur;
  logic           si_prev;
  logic           step_d, dir_d, zero_d, err_d, fwd;
  logic [ERR_W-1:0] cnt_d;

  assign cur = lines[2:1];
  // Forward order 00->01->11->10->00: the next forward state is {prev[0], ~prev[1]}
  assign fwd = (cur == {prev[0], ~prev[1]});

  // State register; prev and si_prev follow the lines every cycle so the
  // value captured on the INIT->TRACK transition reflects the pins at release
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state    <= S_INIT;
      init_cnt <= '0;
      prev     <= '0;
      si_prev  <= 1'b0;
    end else begin
      state   <= state_nxt;
      prev    <= cur;
      si_prev <= lines[0];
      if (state == S_INIT) init_cnt <= init_cnt + ICW'(1);
    end
  end

  // INIT lasts until the synchroniser (and filter) hold real pin values
  always_comb begin
    state_nxt = state;
    if (state == S_INIT && init_cnt == ICW'(INIT_WAIT)) state_nxt = S_TRACK;
  end

  // Decode the phase change and index edge into next-cycle pulses
  always_comb begin
    step_d = 1'b0;
    err_d  = 1'b0;
    zero_d = 1'b0;
    dir_d  = dir;
    cnt_d  = err_cnt;
    if (state == S_TRACK) begin
      zero_d = lines[0] & ~si_prev;
      case (prev ^ cur)
        2'b01, 2'b10: begin
          step_d = 1'b1;
          dir_d  = fwd;
        end
        2'b11: begin
          err_d = 1'b1;
          if (err_cnt != {ERR_W{1'b1}}) cnt_d = err_cnt + ERR_W'(1);
        end
        default: ;
      endcase
    end
  end

  // Registered outputs
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      step    <= 1'b0;
      dir     <= 1'b1;
      zero    <= 1'b0;
      err     <= 1'b0;
      err_cnt <= '0;
    end else begin
      step    <= step_d;
      dir     <= dir_d;
      zero    <= zero_d;
      err     <= err_d;
      err_cnt <= cnt_d;
    end
  end

endmodule

// File: tb/tb_quad_decoder.sv
// tb/tb_quad_decoder.sv - scoreboard bench for quad_decoder
module tb_quad_decoder;
  localparam int ERR_W = 8;
`ifdef QDEC_FILTER_EN
  localparam int LAT = 7;
`else
  localparam int LAT = 3;
`endif

  logic             clk = 1'b0;
  logic             reset_n = 1'b0;
  logic             qa = 1'b1;
  logic             qb = 1'b1;
  logic             qi = 1'b0;
  logic             step, dir, zero, err;
  logic [ERR_W-1:0] err_cnt;

  quad_decoder #(.SYNC_STAGES(2), .FILTER_LEN(4), .ERR_W(ERR_W)) dut (
    .clk(clk), .reset_n(reset_n), .qa(qa), .qb(qb), .qi(qi),
    .step(step), .dir(dir), .zero(zero), .err(err), .err_cnt(err_cnt)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int at;
    bit is_err;
    bit d;
    int cnt;
  } ab_exp_t;

  ab_exp_t q_ab[$];
  int      q_z[$];
  int      n_vec = 0;
  int      n_err = 0;
  ab_exp_t e;
  int      zat;

  task automatic chk(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic chk_reset();
    chk("rst_step", int'(step), 0);
    chk("rst_dir", int'(dir), 1);
    chk("rst_zero", int'(zero), 0);
    chk("rst_err", int'(err), 0);
    chk("rst_err_cnt", int'(err_cnt), 0);
  endtask

  // Monitor: pops expectations whenever the DUT pulses, flags missing pulses
  always @(negedge clk) begin
    if (reset_n) begin
      if (step || err) begin
        if (q_ab.size() == 0) begin
          n_vec++;
          n_err++;
          $display("FAIL unexpected_ab: step=%0d err=%0d at cycle %0d, none expected", step, err, cyc);
        end else begin
          e = q_ab.pop_front();
          chk("ab_cycle", cyc, e.at);
          chk("ab_err", int'(err), int'(e.is_err));
          chk("ab_step", int'(step), int'(!e.is_err));
          chk("ab_dir", int'(dir), int'(e.d));
          if (e.is_err) chk("err_cnt", int'(err_cnt), e.cnt);
        end
      end
      if (zero) begin
        if (q_z.size() == 0) begin
          n_vec++;
          n_err++;
          $display("FAIL unexpected_zero: zero=1 at cycle %0d, none expected", cyc);
        end else begin
          zat = q_z.pop_front();
          chk("zero_cycle", cyc, zat);
        end
      end
      if (q_ab.size() != 0 && q_ab[0].at < cyc) begin
        e = q_ab.pop_front();
        chk("ab_missing_pulse_at", cyc, e.at);
      end
      if (q_z.size() != 0 && q_z[0] < cyc) begin
        zat = q_z.pop_front();
        chk("zero_missing_pulse_at", cyc, zat);
      end
    end
  end

  task automatic drive(input logic a, input logic b, input logic i, input bit exp_ab,
                       input bit is_err, input bit d, input int cnt, input bit exp_z);
    ab_exp_t x;
    @(negedge clk);
    qa = a;
    qb = b;
    qi = i;
    if (exp_ab) begin
      x.at = cyc + LAT;
      x.is_err = is_err;
      x.d = d;
      x.cnt = cnt;
      q_ab.push_back(x);
    end
    if (exp_z) q_z.push_back(cyc + LAT);
    repeat (3) @(negedge clk);
  endtask

  task automatic stp(input logic a, input logic b, input bit d);
    drive(a, b, qi, 1'b1, 1'b0, d, 0, 1'b0);
  endtask

  task automatic jmp(input logic a, input logic b, input bit d, input int cnt);
    drive(a, b, qi, 1'b1, 1'b1, d, cnt, 1'b0);
  endtask

  initial begin
    // Reset held with AB=11
    repeat (3) @(negedge clk);
    chk_reset();
    reset_n = 1'b1;
    repeat (10) @(negedge clk);

    // 11 -> 10 -> 00 forward, then a full forward cycle
    stp(1, 0, 1);
    stp(0, 0, 1);
    stp(0, 1, 1);
    stp(1, 1, 1);
    stp(1, 0, 1);
    stp(0, 0, 1);

    // Reverse 00 -> 10 -> 11 -> 01, then one forward edge, then reverse again
    stp(1, 0, 0);
    stp(1, 1, 0);
    stp(0, 1, 0);
    stp(1, 1, 1);
    repeat (LAT + 1) @(negedge clk);
    chk("dir_hold_fwd", int'(dir), 1);
    stp(0, 1, 0);

    // Index rises together with a forward edge, held high 20 cycles
    drive(1, 1, 1, 1'b1, 1'b0, 1'b1, 0, 1'b1);
    stp(1, 0, 1);
    stp(0, 0, 1);
    repeat (8) @(negedge clk);
    drive(0, 0, 0, 1'b0, 1'b0, 1'b0, 0, 1'b0);
    // Index pulse with no motion
    drive(0, 0, 1, 1'b0, 1'b0, 1'b0, 0, 1'b1);
    drive(0, 0, 0, 1'b0, 1'b0, 1'b0, 0, 1'b0);

    // Double-edge errors with dir=0; counter saturates at 255
    stp(1, 0, 0);
    for (int k = 1; k <= 300; k++) begin
      if (k % 2 == 1) jmp(0, 1, 0, (k > 255) ? 255 : k);
      else            jmp(1, 0, 0, (k > 255) ? 255 : k);
    end
    repeat (LAT + 1) @(negedge clk);
    chk("err_cnt_sat", int'(err_cnt), 255);
    stp(0, 0, 1);
    stp(1, 0, 0);
    repeat (LAT + 1) @(negedge clk);

    // Reset mid-operation; pins jump and index is high across release
    @(negedge clk);
    reset_n = 1'b0;
    #1;
    chk_reset();
    qa = 1'b0;
    qb = 1'b1;
    qi = 1'b1;
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    repeat (12) @(negedge clk);
    chk("post_rst_err_cnt", int'(err_cnt), 0);
    chk("post_rst_dir", int'(dir), 1);
    drive(1, 1, 0, 1'b1, 1'b0, 1'b1, 0, 1'b0);
    jmp(0, 0, 1, 1);

`ifdef QDEC_FILTER_EN
    // Short glitch on qa is suppressed; a stable edge still decodes
    @(negedge clk);
    qa = 1'b1;
    repeat (3) @(negedge clk);
    qa = 1'b0;
    repeat (10) @(negedge clk);
    drive(1, 0, 0, 1'b1, 1'b0, 1'b0, 0, 1'b0);
    repeat (2) @(negedge clk);
`endif

    for (int i = 0; i < 20 && (q_ab.size() != 0 || q_z.size() != 0); i++) @(negedge clk);
    chk("ab_queue_drained", q_ab.size(), 0);
    chk("zero_queue_drained", q_z.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
